// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin sharing of one fixed-latency pipelined divider among N requesters
// Optional macro DIV_SHARE_ARBITER_DBZ_EN: saturate divide-by-zero results and flag them on rsp_err.
module div_share_arbiter #(
    parameter int N        = 4,
    parameter int DIVIDEND = 32,
    parameter int DIVISOR  = 24,
    parameter int QUOTIENT = 32,
    parameter int MAX_OUT  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N-1:0]                 req_valid,
    output logic [N-1:0]                 req_ready,
    input  logic [N*DIVIDEND-1:0]        req_dividend,
    input  logic [N*DIVISOR-1:0]         req_divisor,
    output logic [N-1:0]                 rsp_valid,
    output logic [QUOTIENT-1:0]          rsp_quotient,
    output logic                         rsp_err,
    output logic                         div_ivalid,
    output logic [DIVIDEND-1:0]          div_dividend,
    output logic [DIVISOR-1:0]           div_divisor,
    input  logic                         div_ovalid,
    input  logic [QUOTIENT-1:0]          div_quotient,
    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic                         tag_err
);

    localparam int IDXW = $clog2(N);
    localparam int AW   = $clog2(MAX_OUT);
    localparam int CW   = AW + 1;
`ifdef DIV_SHARE_ARBITER_DBZ_EN
    localparam int ENTRY_W = IDXW + 2;
`else
    localparam int ENTRY_W = IDXW;
`endif

    logic [DIVIDEND-1:0] dividend_arr [N];
    logic [DIVISOR-1:0]  divisor_arr  [N];

    logic [IDXW-1:0]     ptr;
    logic [IDXW-1:0]     grant;
    logic [IDXW-1:0]     cand;
    logic                found;
    logic                can_issue;
    logic                issue;
    logic                pop;
    logic                empty_pop;

    logic [ENTRY_W-1:0]  fifo_mem [MAX_OUT];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  pop_entry;
    logic [IDXW-1:0]     pop_tag;
    logic [QUOTIENT-1:0] ret_quotient;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dividend_arr[i] = req_dividend[i*DIVIDEND +: DIVIDEND];
            divisor_arr[i]  = req_divisor[i*DIVISOR +: DIVISOR];
        end
    end

    // Search upward from the slot after the last winner, wrapping around.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDXW'((int'(ptr) + k) % N);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign can_issue = (outstanding < CW'(MAX_OUT));
    assign issue     = can_issue && found;
    assign req_ready = issue ? (N'(1) << grant) : '0;
    assign pop       = div_ovalid && (outstanding != '0);
    assign empty_pop = div_ovalid && (outstanding == '0);

    assign pop_entry = fifo_mem[rd_ptr];
    assign pop_tag   = pop_entry[IDXW-1:0];

`ifdef DIV_SHARE_ARBITER_DBZ_EN
    logic ret_dbz;
    logic ret_sign;

    assign push_entry = {(divisor_arr[grant] == '0), dividend_arr[grant][DIVIDEND-1], grant};
    assign ret_dbz    = pop_entry[IDXW+1];
    assign ret_sign   = pop_entry[IDXW];

    // A zero divisor still goes through the divider so results stay in issue order.
    always_comb begin
        ret_quotient = div_quotient;
        if (ret_dbz) begin
            ret_quotient = ret_sign ? {1'b1, {(QUOTIENT-1){1'b0}}} : {1'b0, {(QUOTIENT-1){1'b1}}};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= pop && ret_dbz;
        end
    end
`else
    assign push_entry   = grant;
    assign ret_quotient = div_quotient;
    assign rsp_err      = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (issue) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr          <= IDXW'(N - 1);
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            outstanding  <= '0;
            tag_err      <= 1'b0;
            div_ivalid   <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            rsp_valid    <= '0;
            rsp_quotient <= '0;
        end else begin
            if (issue) begin
                div_ivalid   <= 1'b1;
                div_dividend <= dividend_arr[grant];
                div_divisor  <= divisor_arr[grant];
                ptr          <= grant;
                wr_ptr       <= wr_ptr + AW'(1);
            end else begin
                div_ivalid   <= 1'b0;
            end

            if (pop) begin
                rd_ptr       <= rd_ptr + AW'(1);
                rsp_valid    <= N'(1) << pop_tag;
                rsp_quotient <= ret_quotient;
            end else begin
                rsp_valid    <= '0;
            end

            if (empty_pop) begin
                tag_err <= 1'b1;
            end

            case ({issue, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - scoreboard bench for div_share_arbiter driving a 7-cycle divider stub
`timescale 1ns/1ps
module tb_div_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int VW = 24;
    localparam int QW = 32;
    localparam int MO = 4;
    localparam int CW = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     opa [N];
    logic [VW-1:0]     opb [N];
    logic [N*DW-1:0]   req_dividend;
    logic [N*VW-1:0]   req_divisor;
    logic [N-1:0]      rsp_valid;
    logic [QW-1:0]     rsp_quotient;
    logic              rsp_err;
    logic              div_ivalid;
    logic [DW-1:0]     div_dividend;
    logic [VW-1:0]     div_divisor;
    logic              div_ovalid;
    logic [QW-1:0]     div_quotient;
    logic [CW-1:0]     outstanding;
    logic              tag_err;

    assign req_dividend = {opa[3], opa[2], opa[1], opa[0]};
    assign req_divisor  = {opb[3], opb[2], opb[1], opb[0]};

    div_share_arbiter #(.N(N), .DIVIDEND(DW), .DIVISOR(VW), .QUOTIENT(QW), .MAX_OUT(MO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_err(rsp_err),
        .div_ivalid(div_ivalid), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ovalid(div_ovalid), .div_quotient(div_quotient),
        .outstanding(outstanding), .tag_err(tag_err)
    );

    always #5 clock = ~clock;

    function automatic logic [QW-1:0] model_div(input logic [DW-1:0] a, input logic [VW-1:0] b);
        logic signed [DW-1:0] sa;
        logic signed [DW-1:0] sb;
        sa = a;
        sb = DW'($signed(b));
        if (b == '0) return 32'hDEAD_BEEF;
        return sa / sb;
    endfunction

    // Divider stub: sampled at the edge after div_ivalid rises, ovalid 7 edges later; not reset.
    logic [7:0]    pv = '0;
    logic [QW-1:0] pq [8];
    always @(posedge clock) begin
        pv    <= {pv[6:0], div_ivalid};
        pq[0] <= model_div(div_dividend, div_divisor);
        for (int k = 1; k < 8; k++) pq[k] <= pq[k-1];
    end
    assign div_ovalid   = pv[7];
    assign div_quotient = pq[7];

    typedef struct packed {
        logic [N-1:0]  id;
        logic [QW-1:0] q;
        logic          err;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [N-1:0] mon_hs;
    int           vectors = 0;
    int           miscompares = 0;
    int           rsp_seen = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (rsp_valid != '0) begin
                rsp_seen++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b q=%h with nothing expected", rsp_valid, rsp_quotient);
                end else begin
                    mon_e = sb.pop_front();
                    if ({rsp_valid, rsp_quotient, rsp_err} !== {mon_e.id, mon_e.q, mon_e.err}) begin
                        miscompares++;
                        $display("FAIL rsp_data: got valid=%b q=%h err=%b, want valid=%b q=%h err=%b",
                                 rsp_valid, rsp_quotient, rsp_err, mon_e.id, mon_e.q, mon_e.err);
                    end
                end
            end
            mon_hs = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (mon_hs[i]) begin
                    mon_e.id = 4'b0001 << i;
                    if (opb[i] == '0) begin
`ifdef DIV_SHARE_ARBITER_DBZ_EN
                        mon_e.q   = opa[i][DW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        mon_e.err = 1'b1;
`else
                        mon_e.q   = 32'hDEAD_BEEF;
                        mon_e.err = 1'b0;
`endif
                    end else begin
                        mon_e.q   = model_div(opa[i], opb[i]);
                        mon_e.err = 1'b0;
                    end
                    sb.push_back(mon_e);
                end
            end
        end
    end

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (sb.size() == 0 && outstanding == '0 && !div_ovalid) break;
        end
        vectors++;
        if (sb.size() != 0 || outstanding !== '0) begin
            miscompares++;
            $display("FAIL drain: %0d results pending, outstanding=%0d, want 0/0", sb.size(), outstanding);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if ({rsp_valid, rsp_quotient, rsp_err, div_ivalid, div_dividend, div_divisor, outstanding, tag_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rsp_valid=%b q=%h div_ivalid=%b outstanding=%0d tag_err=%b, want all 0",
                     rsp_valid, rsp_quotient, div_ivalid, outstanding, tag_err);
        end
        reset = 1'b0;
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_priority: req_ready=%b, want 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        int lat;
        lat = -1;
        @(posedge clock); #1;
        opa[0] = 32'd100;
        opb[0] = 24'd7;
        req_valid = 4'b0001;
        @(posedge clock); #1;
        req_valid = '0;
        vectors++;
        if ({div_ivalid, div_dividend, div_divisor, outstanding} !== {1'b1, 32'd100, 24'd7, 3'd1}) begin
            miscompares++;
            $display("FAIL single_issue: ivalid=%b a=%0d b=%0d out=%0d, want 1 100 7 1",
                     div_ivalid, div_dividend, div_divisor, outstanding);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (rsp_valid != '0) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL single_latency: rsp after %0d edges, want 9", lat);
        end
        vectors++;
        if ({rsp_valid, rsp_quotient, outstanding} !== {4'b0001, 32'd14, 3'd0}) begin
            miscompares++;
            $display("FAIL single_result: valid=%b q=%0d out=%0d, want 0001 14 0", rsp_valid, rsp_quotient, outstanding);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int exp_id;
        int grants;
        exp_id = 1;
        grants = 0;
        @(posedge clock); #1;
        opa[0] = 32'd1000;       opb[0] = 24'd3;
        opa[1] = 32'd2222;       opb[1] = 24'hFFFFFB;
        opa[2] = 32'd98765;      opb[2] = 24'd11;
        opa[3] = 32'hFFFF_FCF7;  opb[3] = 24'd6;
        req_valid = 4'b1111;
        for (int c = 0; c < 200 && grants < 12; c++) begin
            @(negedge clock);
            if (req_ready != '0) begin
                vectors++;
                if (req_ready !== (4'b0001 << exp_id)) begin
                    miscompares++;
                    $display("FAIL rr_grant: grant %0d req_ready=%b, want %b", grants, req_ready, 4'b0001 << exp_id);
                end
                exp_id = (exp_id + 1) % N;
                grants++;
            end
        end
        @(posedge clock); #1;
        req_valid = '0;
        vectors++;
        if (grants != 12) begin
            miscompares++;
            $display("FAIL rr_count: %0d grants observed, want 12", grants);
        end
        drain();
    endtask

    task automatic test_max_out();
        int issues;
        int first_rsp;
        logic [CW-1:0] maxo;
        issues = 0;
        first_rsp = 0;
        maxo = '0;
        @(posedge clock); #1;
        opb[0] = 24'd3;
        opa[0] = 32'd2000;
        req_valid = 4'b0001;
        for (int c = 1; c < 40; c++) begin
            @(negedge clock);
            if (outstanding > maxo) maxo = outstanding;
            if (rsp_valid != '0) first_rsp = 1;
            if (!first_rsp) begin
                if (outstanding == CW'(MO)) begin
                    vectors++;
                    if (req_ready !== '0) begin
                        miscompares++;
                        $display("FAIL max_out_stall: req_ready=%b at outstanding=%0d, want 0000", req_ready, outstanding);
                    end
                end
                if (req_ready[0]) issues++;
            end
            @(posedge clock); #1;
            opa[0] = 32'd2000 + 32'(17 * c);
        end
        req_valid = '0;
        vectors++;
        if (issues != MO) begin
            miscompares++;
            $display("FAIL max_out_issues: %0d issues before first pop, want %0d", issues, MO);
        end
        vectors++;
        if (maxo !== CW'(MO)) begin
            miscompares++;
            $display("FAIL max_out_peak: peak outstanding %0d, want %0d", maxo, MO);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        @(posedge clock); #1;
        opa[1] = 32'd700;  opb[1] = 24'd7;
        opa[2] = 32'd800;  opb[2] = 24'd9;
        opa[3] = 32'd900;  opb[3] = 24'd2;
        opa[0] = 32'd4321; opb[0] = 24'd10;
        req_valid = 4'b0010;
        @(posedge clock); #1; req_valid = 4'b0100;
        @(posedge clock); #1; req_valid = 4'b1000;
        @(posedge clock); #1; req_valid = '0;
        repeat (6) @(posedge clock);
        #1;
        vectors++;
        if (outstanding !== 3'd3) begin
            miscompares++;
            $display("FAIL simul_pre: outstanding=%0d, want 3", outstanding);
        end
        req_valid = 4'b0001;
        @(posedge clock); #1;
        req_valid = '0;
        vectors++;
        if ({outstanding, rsp_valid, div_ivalid} !== {3'd3, 4'b0010, 1'b1}) begin
            miscompares++;
            $display("FAIL simul_boundary: out=%0d rsp_valid=%b ivalid=%b, want 3 0010 1", outstanding, rsp_valid, div_ivalid);
        end
        drain();
    endtask

`ifdef DIV_SHARE_ARBITER_DBZ_EN
    task automatic test_dbz();
        for (int t = 0; t < 2; t++) begin
            @(posedge clock); #1;
            opa[2] = (t == 0) ? 32'hFFFF_FFCE : 32'd50;
            opb[2] = '0;
            req_valid = 4'b0100;
            @(posedge clock); #1;
            req_valid = '0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clock);
                if (rsp_valid != '0) break;
            end
            vectors++;
            if ({rsp_valid, rsp_err, rsp_quotient} !== {4'b0100, 1'b1, (t == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF}) begin
                miscompares++;
                $display("FAIL dbz_%0d: valid=%b err=%b q=%h", t, rsp_valid, rsp_err, rsp_quotient);
            end
            drain();
        end
    endtask
`endif

    task automatic test_reset_mid();
        int seen_before;
        vectors++;
        if (tag_err !== 1'b0) begin
            miscompares++;
            $display("FAIL tag_err_clean: tag_err=%b, want 0", tag_err);
        end
        @(posedge clock); #1;
        opa[1] = 32'd11; opa[2] = 32'd22; opa[3] = 32'd33;
        opb[1] = 24'd1;  opb[2] = 24'd2;  opb[3] = 24'd3;
        req_valid = 4'b0010;
        @(posedge clock); #1; req_valid = 4'b0100;
        @(posedge clock); #1; req_valid = 4'b1000;
        @(posedge clock); #1; req_valid = '0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        sb.delete();
        vectors++;
        if ({rsp_valid, div_ivalid, outstanding, tag_err, rsp_quotient} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_async: rsp_valid=%b ivalid=%b out=%0d tag_err=%b q=%h, want all 0",
                     rsp_valid, div_ivalid, outstanding, tag_err, rsp_quotient);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        seen_before = rsp_seen;
        repeat (12) @(posedge clock);
        #1;
        vectors++;
        if ({tag_err, outstanding} !== {1'b1, 3'd0} || rsp_seen != seen_before) begin
            miscompares++;
            $display("FAIL reset_mid_stale: tag_err=%b out=%0d extra_rsp=%0d, want 1 0 0",
                     tag_err, outstanding, rsp_seen - seen_before);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        vectors++;
        if (tag_err !== 1'b0) begin
            miscompares++;
            $display("FAIL tag_err_clear: tag_err=%b after reset, want 0", tag_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = 24'd1;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_max_out();
        test_simultaneous();
`ifdef DIV_SHARE_ARBITER_DBZ_EN
        test_dbz();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one pipelined signed divider instance (fixed latency, no backpressure) among N requesters.
- Round-robin arbitration picks one requester per cycle. The block registers its operands into the divider and tracks the requester ID of each in-flight operation in a tag FIFO.
- Each returned quotient is routed back to its originating requester.
- Sits between the client blocks and the divider datapath; it is the only driver of the divider's input port.

Parameters:
- N, 4, number of requesters (2..16)
- DIVIDEND, 32, dividend width
- DIVISOR, 24, divisor width
- QUOTIENT, 32, quotient width
- MAX_OUT, 8, maximum outstanding operations and tag FIFO depth; a power of 2, at least 2

Ports:
- clock  in  1  clock
- reset  in  1  reset
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester grant; combinational
- req_dividend  in  N*DIVIDEND  packed operands; requester i occupies bits [i*DIVIDEND +: DIVIDEND]
- req_divisor  in  N*DIVISOR  packed operands; same packing scheme
- rsp_valid  out  N  one-hot result strobe, registered
- rsp_quotient  out  QUOTIENT  shared result bus, valid with rsp_valid
- rsp_err  out  1  divide-by-zero flag with the result (optional feature only; tied 0 otherwise)
- div_ivalid  out  1  to divider ivalid, registered
- div_dividend  out  DIVIDEND  to divider, registered
- div_divisor  out  DIVISOR  to divider, registered
- div_ovalid  in  1  from divider ovalid
- div_quotient  in  QUOTIENT  from divider quotient
- outstanding  out  clog2(MAX_OUT)+1  in-flight count
- tag_err  out  1  sticky: div_ovalid arrived with tag FIFO empty

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clock, rising edge.
- Reset values: all registered outputs 0; RR pointer = N-1, so requester 0 has priority first; tag FIFO empty; tag_err = 0.
- Reset mid-operation: in-flight tags are discarded. Quotients arriving after reset release with an empty FIFO set tag_err and produce no rsp_valid.
- Issue condition: can_issue = (outstanding < MAX_OUT).
- Arbitration: grant goes to the first i with req_valid[i] set, searching upward from (ptr+1) mod N and wrapping.
  - req_ready = one-hot(grant) when can_issue, else all 0.
  - req_ready never depends on req_valid of the granted requester except through grant selection.
- Handshake: req_valid[i] & req_ready[i] at a rising edge. On that edge:
  - div_ivalid <= 1 and div_dividend/div_divisor <= slice i;
  - push tag i into the FIFO;
  - ptr <= i.
- With no handshake: div_ivalid <= 0 and operand registers hold.
- Return path: when div_ovalid is sampled high, pop the tag.
  - rsp_valid <= one-hot(tag) and rsp_quotient <= div_quotient on that edge.
  - Otherwise rsp_valid <= 0 and rsp_quotient holds.
- Latency: handshake edge t0 → div_ivalid sampled by the divider at t0+1 → div_ovalid high after t0+8 (divider latency 7) → rsp_valid high after t0+9. Equivalently, divider latency + 2 edges.
- Throughput: one issue per cycle, sustained, while outstanding < MAX_OUT.
- Ordering: results return in issue order. The divider is in-order, so no reordering logic is used.
- outstanding:
  - +1 on issue only;
  - -1 on pop only;
  - unchanged on a simultaneous issue and pop.
  - A pop in the same cycle as outstanding == MAX_OUT does not enable issue that cycle, because can_issue uses the registered count.
- FIFO boundaries:
  - push when full cannot occur (guarded by can_issue);
  - pop when empty sets tag_err (sticky until reset), with no rsp_valid and no FIFO pointer change.
- Arithmetic: operands are passed through unmodified as signed values. The block performs no sign or width conversion.

Optional Feature:
- Macro: DIV_SHARE_ARBITER_DBZ_EN.
- Enabled:
  - the tag FIFO entry carries a dbz bit = (selected divisor == 0), captured at issue;
  - the request is still issued to the divider to preserve ordering;
  - on return with dbz = 1, rsp_quotient = max positive {0, all-ones} if the dividend sign bit is 0, else the most negative value {1, zeros}, and rsp_err = 1. The dividend sign is also stored in the FIFO entry.
- Disabled: no dbz bit in the FIFO; divider output is passed through unchanged; rsp_err is constant 0.

Test Plan:
- Single request: req0 with 100/7 at t0 → div_ivalid at t0+1 with 100/7; rsp_valid = 4'b0001 after t0+9; rsp_quotient = divider output; outstanding steps 0→1→0.
- All four requesters valid every cycle → grants cycle 0,1,2,3,0,…; rsp_valid sequence 0001,0010,0100,1000 with one result per cycle after the latency.
- MAX_OUT = 4 with a 7-cycle divider and continuous req0 → exactly 4 issues, then req_ready = 0 until the first pop; outstanding never exceeds 4.
- Reset asserted with 3 operations in flight → outputs 0 immediately; the 3 stale div_ovalid pulses set tag_err = 1 and produce no rsp_valid.
- DBZ enabled: req2 with -50/0 → rsp_valid = 4'b0100, rsp_err = 1, rsp_quotient = 32'h80000000. Then 50/0 → 32'h7FFFFFFF, rsp_err = 1.
- Simultaneous issue and pop at outstanding = 3 → outstanding stays 3; tag order is preserved across the boundary.
